// File: rtl/lut_decoder_pkg.sv
// Shared constants for the BKM LUT decoder checker: CSD digit codes and latency limits.
package lut_decoder_pkg;

  localparam logic [1:0] CSD_ZERO = 2'b00;
  localparam logic [1:0] CSD_POS  = 2'b01;
  localparam logic [1:0] CSD_ILL  = 2'b10;
  localparam logic [1:0] CSD_NEG  = 2'b11;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

endpackage

// File: rtl/csd_chk.sv
// Combinational CSD-to-binary decode for one channel, flagging illegal digit codes
// and adjacent nonzero digits.
module csd_chk
  import lut_decoder_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [2*W-1:0] csd,
  output logic [W-1:0]   bin,
  output logic           fmt_err
);

  logic [W-1:0] pos;
  logic [W-1:0] neg;
  logic [W-1:0] nz;
  logic         ill;

  // An illegal code contributes nothing to the value and does not count as nonzero.
  always_comb begin
    pos = '0;
    neg = '0;
    ill = 1'b0;
    for (int i = 0; i < W; i++) begin
      case (csd[2*i +: 2])
        CSD_POS:  pos[i] = 1'b1;
        CSD_NEG:  neg[i] = 1'b1;
        CSD_ILL:  ill    = 1'b1;
        CSD_ZERO: ;
        default:  ;
      endcase
    end
  end

  assign nz      = pos | neg;
  assign fmt_err = ill | (|(nz[W-1:1] & nz[W-2:0]));
  assign bin     = pos - neg;

endmodule

// File: rtl/lut_decoder_checker.sv
// Pipelined multi-channel CSD decode/compare monitor with saturating run statistics.
module lut_decoder_checker
  import lut_decoder_pkg::*;
#(
  parameter int W     = 64,
  parameter int C     = 2,
  parameter int LAT   = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               srst,
  input  logic               enable,
  input  logic               in_valid,
  input  logic [C*2*W-1:0]   csd,
  input  logic [C*W-1:0]     exp,
  output logic [C*W-1:0]     res,
  output logic               res_valid,
  output logic [C-1:0]       mismatch,
  output logic [C-1:0]       fmt_err,
  output logic               sticky_err,
  output logic [CNT_W-1:0]   sample_cnt,
  output logic [CNT_W-1:0]   err_cnt
);

  localparam int MID = (LAT > 2) ? LAT - 2 : 0;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_bad_lat
    $error("lut_decoder_checker: LAT=%0d outside %0d..%0d", LAT, LAT_MIN, LAT_MAX);
  end

  logic               f_valid;
  logic [C*2*W-1:0]   f_csd;
  logic [C*W-1:0]     f_exp;

  // With LAT=1 the raw inputs feed the decode logic straight into the output register.
  if (LAT == 1) begin : g_front_comb
    assign f_valid = in_valid;
    assign f_csd   = csd;
    assign f_exp   = exp;
  end else begin : g_front_reg
    always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
        f_valid <= 1'b0;
        f_csd   <= '0;
        f_exp   <= '0;
      end else if (srst) begin
        f_valid <= 1'b0;
        f_csd   <= '0;
        f_exp   <= '0;
      end else if (enable) begin
        f_valid <= in_valid;
        f_csd   <= csd;
        f_exp   <= exp;
      end
    end
  end

  logic [C*W-1:0] d_bin;
  logic [C-1:0]   d_fmt;
  logic [C-1:0]   d_mis;

  for (genvar k = 0; k < C; k++) begin : g_chan
    csd_chk #(.W(W)) u_chk (
      .csd     (f_csd[k*2*W +: 2*W]),
      .bin     (d_bin[k*W +: W]),
      .fmt_err (d_fmt[k])
    );
    assign d_mis[k] = (d_bin[k*W +: W] != f_exp[k*W +: W]);
  end

  logic           o_valid;
  logic [C*W-1:0] o_bin;
  logic [C-1:0]   o_fmt;
  logic [C-1:0]   o_mis;

  // Extra latency beyond two stages is carried as already-decoded results.
  if (MID > 0) begin : g_mid
    logic [MID-1:0]            q_valid;
    logic [MID-1:0][C*W-1:0]   q_bin;
    logic [MID-1:0][C-1:0]     q_fmt;
    logic [MID-1:0][C-1:0]     q_mis;

    always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
        q_valid <= '0;
        q_bin   <= '0;
        q_fmt   <= '0;
        q_mis   <= '0;
      end else if (srst) begin
        q_valid <= '0;
        q_bin   <= '0;
        q_fmt   <= '0;
        q_mis   <= '0;
      end else if (enable) begin
        q_valid[0] <= f_valid;
        q_bin[0]   <= d_bin;
        q_fmt[0]   <= d_fmt;
        q_mis[0]   <= d_mis;
        for (int j = 1; j < MID; j++) begin
          q_valid[j] <= q_valid[j-1];
          q_bin[j]   <= q_bin[j-1];
          q_fmt[j]   <= q_fmt[j-1];
          q_mis[j]   <= q_mis[j-1];
        end
      end
    end

    assign o_valid = q_valid[MID-1];
    assign o_bin   = q_bin[MID-1];
    assign o_fmt   = q_fmt[MID-1];
    assign o_mis   = q_mis[MID-1];
  end else begin : g_no_mid
    assign o_valid = f_valid;
    assign o_bin   = d_bin;
    assign o_fmt   = d_fmt;
    assign o_mis   = d_mis;
  end

  // Output stage: flags only live while res_valid is high, res keeps the last sample,
  // and statistics move on the same edge that presents a sample.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      res        <= '0;
      res_valid  <= 1'b0;
      mismatch   <= '0;
      fmt_err    <= '0;
      sticky_err <= 1'b0;
      sample_cnt <= '0;
      err_cnt    <= '0;
    end else if (srst) begin
      res        <= '0;
      res_valid  <= 1'b0;
      mismatch   <= '0;
      fmt_err    <= '0;
      sticky_err <= 1'b0;
      sample_cnt <= '0;
      err_cnt    <= '0;
    end else if (enable) begin
      res_valid <= o_valid;
      if (o_valid) begin
        res      <= o_bin;
        mismatch <= o_mis;
        fmt_err  <= o_fmt;
        if (sample_cnt != '1) begin
          sample_cnt <= sample_cnt + CNT_ONE;
        end
        if (|(o_mis | o_fmt)) begin
          sticky_err <= 1'b1;
          if (err_cnt != '1) begin
            err_cnt <= err_cnt + CNT_ONE;
          end
        end
      end else begin
        mismatch <= '0;
        fmt_err  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lut_decoder_checker.sv
// Directed self-checking bench for lut_decoder_checker at W=8, C=2, LAT=2, CNT_W=4.
module tb_lut_decoder_checker;

  localparam int W     = 8;
  localparam int C     = 2;
  localparam int LAT   = 2;
  localparam int CNT_W = 4;

  logic               clk;
  logic               arst;
  logic               srst;
  logic               enable;
  logic               in_valid;
  logic [C*2*W-1:0]   csd;
  logic [C*W-1:0]     exp;
  logic [C*W-1:0]     res;
  logic               res_valid;
  logic [C-1:0]       mismatch;
  logic [C-1:0]       fmt_err;
  logic               sticky_err;
  logic [CNT_W-1:0]   sample_cnt;
  logic [CNT_W-1:0]   err_cnt;

  int tests;
  int failures;

  lut_decoder_checker #(.W(W), .C(C), .LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .arst       (arst),
    .srst       (srst),
    .enable     (enable),
    .in_valid   (in_valid),
    .csd        (csd),
    .exp        (exp),
    .res        (res),
    .res_valid  (res_valid),
    .mismatch   (mismatch),
    .fmt_err    (fmt_err),
    .sticky_err (sticky_err),
    .sample_cnt (sample_cnt),
    .err_cnt    (err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic v, input logic [31:0] c, input logic [15:0] e);
    in_valid = v;
    csd      = c;
    exp      = e;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One enabled-or-not clock edge, then settle on the falling edge for sampling.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] c0;
    logic [7:0]  e0;
    logic [7:0]  e_prev;
    tests    = 0;
    failures = 0;
    arst     = 1'b1;
    srst     = 1'b0;
    enable   = 1'b1;
    applyStimulus(1'b0, 32'h0, 16'h0);

    #2 arst = 1'b0;
    @(negedge clk);
    checkOutput("arst_res_valid", res_valid, 0);
    checkOutput("arst_sample_cnt", sample_cnt, 0);
    checkOutput("arst_sticky", sticky_err, 0);
    arst = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checkOutput("idle_res_valid", res_valid, 0);
    checkOutput("idle_res", res, 0);
    checkOutput("idle_mismatch", mismatch, 0);
    checkOutput("idle_fmt_err", fmt_err, 0);
    checkOutput("idle_sticky", sticky_err, 0);
    checkOutput("idle_sample_cnt", sample_cnt, 0);
    checkOutput("idle_err_cnt", err_cnt, 0);

    // ch0: +1 at digit 7, -1 at digit 0 -> 128 - 1 = 0x7F; ch1: +1 at digit 0 -> 0x01
    applyStimulus(1'b1, {16'h0001, 16'h4003}, {8'h01, 8'h7F});
    tick();
    applyStimulus(1'b0, 32'h0, 16'h0);
    checkOutput("basic_not_early", res_valid, 0);
    tick();
    checkOutput("basic_res_valid", res_valid, 1);
    checkOutput("basic_res", res, 32'h017F);
    checkOutput("basic_mismatch", mismatch, 0);
    checkOutput("basic_fmt_err", fmt_err, 0);
    tick();
    checkOutput("basic_valid_drop", res_valid, 0);
    checkOutput("basic_res_hold", res, 32'h017F);
    checkOutput("basic_sample_cnt", sample_cnt, 1);
    checkOutput("basic_err_cnt", err_cnt, 0);

    // Illegal digit 0 (decodes 0), then adjacent +1 digits (value 3)
    applyStimulus(1'b1, {16'h0000, 16'h0002}, {8'h00, 8'h00});
    tick();
    applyStimulus(1'b1, {16'h0000, 16'h0005}, {8'h00, 8'h03});
    tick();
    applyStimulus(1'b0, 32'h0, 16'h0);
    checkOutput("fmt_ill_flag", fmt_err, 2'b01);
    checkOutput("fmt_ill_mismatch", mismatch, 0);
    checkOutput("fmt_ill_res", res, 32'h0000);
    tick();
    checkOutput("fmt_adj_flag", fmt_err, 2'b01);
    checkOutput("fmt_adj_res", res, 32'h0003);
    checkOutput("fmt_sticky", sticky_err, 1);
    checkOutput("fmt_err_cnt", err_cnt, 2);
    checkOutput("fmt_sample_cnt", sample_cnt, 3);
    tick();
    checkOutput("fmt_flag_clear", fmt_err, 0);

    // ch0 = 8 matches; ch1 = 2 against expected 3
    applyStimulus(1'b1, {16'h0004, 16'h0040}, {8'h03, 8'h08});
    tick();
    applyStimulus(1'b0, 32'h0, 16'h0);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_pre_valid", res_valid, 0);
    end
    enable = 1'b1;
    tick();
    checkOutput("mis_res_valid", res_valid, 1);
    checkOutput("mis_mask", mismatch, 2'b10);
    checkOutput("mis_fmt_err", fmt_err, 0);
    checkOutput("mis_res", res, 32'h0208);
    checkOutput("mis_err_cnt", err_cnt, 3);
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("stall_hold_valid", res_valid, 1);
      checkOutput("stall_hold_mask", mismatch, 2'b10);
      checkOutput("stall_sample_cnt", sample_cnt, 4);
      checkOutput("stall_err_cnt", err_cnt, 3);
    end
    enable = 1'b1;
    tick();
    checkOutput("mis_valid_drop", res_valid, 0);
    checkOutput("mis_mask_clear", mismatch, 0);
    checkOutput("mis_res_hold", res, 32'h0208);

    // 20 back-to-back samples, ch0 = single +1 digit walking up
    e_prev = 8'h00;
    for (int s = 0; s < 20; s++) begin
      c0 = 16'h0001 << (2 * (s % 8));
      e0 = 8'h01 << (s % 8);
      applyStimulus(1'b1, {16'h0000, c0}, {8'h00, e0});
      tick();
      if (s > 0) begin
        checkOutput("stream_valid", res_valid, 1);
        checkOutput("stream_res", res, {16'h0000, 8'h00, e_prev});
      end
      e_prev = e0;
    end
    applyStimulus(1'b0, 32'h0, 16'h0);
    tick();
    checkOutput("stream_last_valid", res_valid, 1);
    checkOutput("stream_last_res", res, 32'h0008);
    checkOutput("stream_mismatch", mismatch, 0);
    checkOutput("sat_sample_cnt", sample_cnt, 4'hF);
    checkOutput("stream_err_cnt", err_cnt, 3);
    tick();
    checkOutput("stream_end_valid", res_valid, 0);
    checkOutput("sat_sample_hold", sample_cnt, 4'hF);

    // Two flagged samples in flight when srst hits, with enable low to show the override
    applyStimulus(1'b1, {16'h0000, 16'h0002}, 16'h0000);
    tick();
    applyStimulus(1'b1, {16'h0003, 16'h0000}, 16'h0000);
    srst   = 1'b1;
    enable = 1'b0;
    tick();
    srst   = 1'b0;
    enable = 1'b1;
    applyStimulus(1'b0, 32'h0, 16'h0);
    checkOutput("srst_res_valid", res_valid, 0);
    checkOutput("srst_res", res, 0);
    checkOutput("srst_sample_cnt", sample_cnt, 0);
    checkOutput("srst_err_cnt", err_cnt, 0);
    checkOutput("srst_sticky", sticky_err, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("srst_no_emerge", res_valid, 0);
      checkOutput("srst_fmt_err", fmt_err, 0);
      checkOutput("srst_cnt_stay", sample_cnt, 0);
      checkOutput("srst_sticky_stay", sticky_err, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
